// File: rtl/page_map.sv
// page_map: single-clock page allocator built on a WORDS x 32 free bitmap.
// A bit value of 1 means the page is free; page index = {word, bit}.
// A per-word summary register lets allocation find the lowest free page quickly.
// The bitmap RAM is single-port with a synchronous read.
// Optional feature: define PAGE_MAP_DFREE_CHECK_EN to detect double frees and
// latch the first one.
module page_map #(
    parameter int WORD_ABITS     = 5,
    parameter int RESERVED_WORDS = 3,
    parameter int WHO_W          = 4,
    parameter int LOW_WATER      = 64,
    localparam int WORDS         = 1 << WORD_ABITS,
    localparam int PW            = WORD_ABITS + 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             free_req,
    input  logic [PW-1:0]    free_page,
    input  logic [WHO_W-1:0] free_who,
    output logic             free_gnt,
    input  logic             alloc_req,
    output logic             alloc_gnt,
    output logic [PW-1:0]    alloc_page,
    output logic [PW:0]      count,
    output logic             empty,
    output logic             low_water,
    output logic             init_done,
    input  logic             err_clr,
    output logic             double_free_error,
    output logic [PW-1:0]    double_free_page,
    output logic [WHO_W-1:0] double_free_who
);

    localparam int CW = PW + 1;

    localparam logic [2:0] S_INIT       = 3'd0;
    localparam logic [2:0] S_IDLE       = 3'd1;
    localparam logic [2:0] S_FREE_RD    = 3'd2;
    localparam logic [2:0] S_FREE_WR    = 3'd3;
    localparam logic [2:0] S_ALLOC_RD   = 3'd4;
    localparam logic [2:0] S_ALLOC_PICK = 3'd5;
    localparam logic [2:0] S_ALLOC_WR   = 3'd6;

    localparam logic [CW-1:0]         COUNT_MAX  = CW'(WORDS * 32);
    localparam logic [CW-1:0]         COUNT_INIT = CW'((WORDS - RESERVED_WORDS) * 32);
    localparam logic [WORD_ABITS:0]   RES_WORDS  = (WORD_ABITS + 1)'(RESERVED_WORDS);

    // Summary bits for every non-reserved word start out set.
    function automatic logic [WORDS-1:0] summary_reset_value();
        logic [WORDS-1:0] v;
        v = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (i >= RESERVED_WORDS) v[i] = 1'b1;
        end
        return v;
    endfunction

    localparam logic [WORDS-1:0] SUMMARY_INIT = summary_reset_value();

    // Index of the lowest set bit of the summary vector.
    function automatic logic [WORD_ABITS-1:0] lowest_word(input logic [WORDS-1:0] v);
        logic [WORD_ABITS-1:0] idx;
        idx = '0;
        for (int i = WORDS - 1; i >= 0; i--) begin
            if (v[i]) idx = WORD_ABITS'(i);
        end
        return idx;
    endfunction

    // Index of the lowest set bit of a bitmap word.
    function automatic logic [4:0] lowest_bit(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    logic [2:0]            state_q, state_d;
    logic [WORD_ABITS-1:0] init_idx_q, init_idx_d;
    logic [WORDS-1:0]      summary_q, summary_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  prio_alloc_q, prio_alloc_d;
    logic [PW-1:0]         free_page_q, free_page_d;
    logic [WORD_ABITS-1:0] alloc_word_q, alloc_word_d;
    logic [4:0]            alloc_bit_q, alloc_bit_d;
    logic [31:0]           alloc_wdata_q, alloc_wdata_d;
    logic                  free_gnt_q, free_gnt_d;
    logic                  alloc_gnt_q, alloc_gnt_d;

    logic [31:0]           ram_q [WORDS];
    logic [31:0]           ram_rdata_q;
    logic [WORD_ABITS-1:0] ram_addr;
    logic                  ram_we;
    logic [31:0]           ram_wdata;

    logic [WORD_ABITS-1:0] free_word;
    logic [31:0]           free_mask;
    logic                  alloc_ok;

    assign free_word = free_page_q[PW-1:5];
    assign free_mask = 32'(1) << free_page_q[4:0];
    assign alloc_ok  = alloc_req && (count_q != '0);

`ifdef PAGE_MAP_DFREE_CHECK_EN
    logic [WHO_W-1:0] free_who_q, free_who_d;
    logic             err_q, err_d;
    logic [PW-1:0]    err_page_q, err_page_d;
    logic [WHO_W-1:0] err_who_q, err_who_d;
    logic             free_hit;

    assign free_hit = (ram_rdata_q & free_mask) != '0;
`endif

    // Main controller: request arbitration, bitmap walk and free-count upkeep.
    always_comb begin
        state_d       = state_q;
        init_idx_d    = init_idx_q;
        summary_d     = summary_q;
        count_d       = count_q;
        prio_alloc_d  = prio_alloc_q;
        free_page_d   = free_page_q;
        alloc_word_d  = alloc_word_q;
        alloc_bit_d   = alloc_bit_q;
        alloc_wdata_d = alloc_wdata_q;
`ifdef PAGE_MAP_DFREE_CHECK_EN
        free_who_d    = free_who_q;
`endif
        case (state_q)
            S_INIT: begin
                init_idx_d = init_idx_q + WORD_ABITS'(1);
                if (&init_idx_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                // Contention only exists when the alloc could actually be served;
                // the loser of a contention gets priority next time.
                if (free_req && (!alloc_ok || !prio_alloc_q)) begin
                    free_page_d = free_page;
`ifdef PAGE_MAP_DFREE_CHECK_EN
                    free_who_d  = free_who;
`endif
                    state_d     = S_FREE_RD;
                    if (alloc_ok) prio_alloc_d = 1'b1;
                end else if (alloc_ok) begin
                    alloc_word_d = lowest_word(summary_q);
                    state_d      = S_ALLOC_RD;
                    if (free_req) prio_alloc_d = 1'b0;
                end
            end
            S_FREE_RD: begin
                state_d = S_FREE_WR;
            end
            S_FREE_WR: begin
                summary_d[free_word] = 1'b1;
`ifdef PAGE_MAP_DFREE_CHECK_EN
                if (!free_hit && (count_q != COUNT_MAX)) count_d = count_q + CW'(1);
`else
                if (count_q != COUNT_MAX) count_d = count_q + CW'(1);
`endif
                state_d = S_IDLE;
            end
            S_ALLOC_RD: begin
                state_d = S_ALLOC_PICK;
            end
            S_ALLOC_PICK: begin
                alloc_bit_d   = lowest_bit(ram_rdata_q);
                alloc_wdata_d = ram_rdata_q & ~(32'(1) << lowest_bit(ram_rdata_q));
                state_d       = S_ALLOC_WR;
            end
            S_ALLOC_WR: begin
                if (alloc_wdata_q == '0) summary_d[alloc_word_q] = 1'b0;
                count_d = count_q - CW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
        free_gnt_d  = (state_d == S_FREE_RD);
        alloc_gnt_d = (state_d == S_ALLOC_WR);
    end

    // Bitmap port steering: INIT and the WR states write, the RD states read.
    always_comb begin
        ram_addr  = '0;
        ram_we    = 1'b0;
        ram_wdata = '0;
        case (state_q)
            S_INIT: begin
                ram_addr  = init_idx_q;
                ram_we    = 1'b1;
                ram_wdata = ({1'b0, init_idx_q} < RES_WORDS) ? '0 : '1;
            end
            S_FREE_RD: begin
                ram_addr = free_word;
            end
            S_FREE_WR: begin
                ram_addr  = free_word;
                ram_we    = 1'b1;
                ram_wdata = ram_rdata_q | free_mask;
            end
            S_ALLOC_RD: begin
                ram_addr = alloc_word_q;
            end
            S_ALLOC_WR: begin
                ram_addr  = alloc_word_q;
                ram_we    = 1'b1;
                ram_wdata = alloc_wdata_q;
            end
            default: begin
                ram_addr = '0;
            end
        endcase
    end

    // Single-port bitmap RAM with registered read data; contents rebuilt by INIT.
    always_ff @(posedge clk) begin
        if (ram_we) ram_q[ram_addr] <= ram_wdata;
        ram_rdata_q <= ram_q[ram_addr];
    end

    // Controller state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_INIT;
            init_idx_q    <= '0;
            summary_q     <= SUMMARY_INIT;
            count_q       <= COUNT_INIT;
            prio_alloc_q  <= 1'b0;
            free_page_q   <= '0;
            alloc_word_q  <= '0;
            alloc_bit_q   <= '0;
            alloc_wdata_q <= '0;
            free_gnt_q    <= 1'b0;
            alloc_gnt_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            init_idx_q    <= init_idx_d;
            summary_q     <= summary_d;
            count_q       <= count_d;
            prio_alloc_q  <= prio_alloc_d;
            free_page_q   <= free_page_d;
            alloc_word_q  <= alloc_word_d;
            alloc_bit_q   <= alloc_bit_d;
            alloc_wdata_q <= alloc_wdata_d;
            free_gnt_q    <= free_gnt_d;
            alloc_gnt_q   <= alloc_gnt_d;
        end
    end

`ifdef PAGE_MAP_DFREE_CHECK_EN
    // Keep the first double free; a new event in the same cycle as err_clr wins.
    always_comb begin
        err_d      = err_q;
        err_page_d = err_page_q;
        err_who_d  = err_who_q;
        if ((state_q == S_FREE_WR) && free_hit && (!err_q || err_clr)) begin
            err_d      = 1'b1;
            err_page_d = free_page_q;
            err_who_d  = free_who_q;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    // Double-free error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            free_who_q <= '0;
            err_q      <= 1'b0;
            err_page_q <= '0;
            err_who_q  <= '0;
        end else begin
            free_who_q <= free_who_d;
            err_q      <= err_d;
            err_page_q <= err_page_d;
            err_who_q  <= err_who_d;
        end
    end

    assign double_free_error = err_q;
    assign double_free_page  = err_page_q;
    assign double_free_who   = err_who_q;
`else
    logic unused_dfree_inputs;
    assign unused_dfree_inputs = ^{free_who, err_clr};

    assign double_free_error = 1'b0;
    assign double_free_page  = '0;
    assign double_free_who   = '0;
`endif

    assign free_gnt   = free_gnt_q;
    assign alloc_gnt  = alloc_gnt_q;
    assign alloc_page = {alloc_word_q, alloc_bit_q};
    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign low_water  = 32'(count_q) < 32'(LOW_WATER);
    assign init_done  = (state_q != S_INIT);

endmodule
